// File: rtl/apb_master_arb_pkg.sv
// Shared types for the APB master arbiter: FSM state encoding, default bus widths
// and the requester command record.
package apb_ctrl_pkg;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_master_arb_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner, and the pointer
// only moves when the owner of the bus accepts the grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Reset pointer at the last requester so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= IDX_W'(NUM_REQ - 1);
    else if (advance) ptr <= grant_idx;
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by NUM_REQ requesters: round-robin arbitration, SETUP/ACCESS
// sequencing and an ACCESS wait-state timeout. All bus and response outputs are registered.
//
// state  | meaning
// IDLE   | bus idle, PSEL low, waiting for any req_valid
// SETUP  | PSEL high, PENABLE low, req_ready pulsed to the winner
// ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
module apb_master_arb
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e         state, state_nx;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_nx;
  logic [NUM_REQ-1:0] gnt_q, gnt_nx;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gidx;
  logic               done, tmo, advance;

  logic [NUM_REQ-1:0] req_ready_nx, rsp_valid_nx;
  logic [DATA_W-1:0]  rsp_rdata_nx, pwdata_nx;
  logic [ADDR_W-1:0]  paddr_nx;
  logic               rsp_err_nx, pwrite_nx, psel_nx, penable_nx;

  assign done    = (state == ACCESS) && PREADY;
  assign tmo     = (state == ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign advance = ((state == IDLE) || done || tmo) && (|req_valid);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      gnt_q     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_cnt_nx;
      gnt_q     <= gnt_nx;
      req_ready <= req_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
      PADDR     <= paddr_nx;
      PWDATA    <= pwdata_nx;
      PWRITE    <= pwrite_nx;
      PSEL      <= psel_nx;
      PENABLE   <= penable_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = advance ? SETUP : IDLE;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (done || tmo) state_nx = advance ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so they appear registered.
  always_comb begin
    psel_nx      = (state_nx != IDLE);
    penable_nx   = (state_nx == ACCESS);
    paddr_nx     = PADDR;
    pwdata_nx    = PWDATA;
    pwrite_nx    = PWRITE;
    gnt_nx       = gnt_q;
    wait_cnt_nx  = wait_cnt;
    req_ready_nx = '0;
    rsp_valid_nx = '0;
    rsp_rdata_nx = '0;
    rsp_err_nx   = 1'b0;
    if (advance) begin
      paddr_nx     = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
      pwrite_nx    = req_write[gidx];
      pwdata_nx    = req_write[gidx] ? req_wdata[int'(gidx)*DATA_W +: DATA_W] : '0;
      gnt_nx       = grant;
      req_ready_nx = grant;
      wait_cnt_nx  = '0;
    end
    if ((state == ACCESS) && !PREADY && !tmo)
      wait_cnt_nx = wait_cnt + CNT_W'(1);
    if (done || tmo) begin
      rsp_valid_nx = gnt_q;
      rsp_err_nx   = tmo || PSLVERR;
      rsp_rdata_nx = (done && !PWRITE) ? PRDATA : '0;
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: requester agents push expected responses into a
// scoreboard that a negedge monitor pops whenever rsp_valid fires.
module tb_apb_master_arb;
  import apb_ctrl_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                      clk, rst;
  logic [NUM_REQ-1:0]        req_valid, req_write, req_ready, rsp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]         rsp_rdata, PWDATA, PRDATA;
  logic [ADDR_W-1:0]         PADDR;
  logic                      rsp_err, PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   exp_grant[$];
  int   checks = 0;
  int   errors = 0;

  int          slv_waits = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err   = 1'b0;
  int          acc_cnt   = 0;

  apb_master_arb #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [NUM_REQ-1:0] v);
    int r = -1;
    for (int k = 0; k < NUM_REQ; k++) if (v[k]) r = k;
    return r;
  endfunction

  function automatic apb_cmd_t mk_cmd(input logic w, input logic [4:0] a, input logic [31:0] d);
    apb_cmd_t c;
    c.write = w;
    c.addr  = a;
    c.wdata = d;
    return c;
  endfunction

  // Slave: PREADY on ACCESS cycle slv_waits+1.
  always @(posedge clk) begin
    #1;
    if (PSEL && PENABLE) acc_cnt++;
    else acc_cnt = 0;
    PREADY  = PSEL && PENABLE && (acc_cnt > slv_waits);
    PSLVERR = PREADY && slv_err;
    PRDATA  = slv_rdata;
  end

  // Requester agent: present command, wait for req_ready, then drop or keep valid.
  task automatic drive_req(input int i, input apb_cmd_t c, input logic [31:0] exp_rd,
                           input logic exp_err, input bit keep);
    exp_t e;
    bit   got = 1'b0;
    req_valid[i]                 = 1'b1;
    req_write[i]                 = c.write;
    req_addr[i*ADDR_W +: ADDR_W] = c.addr;
    req_wdata[i*DATA_W +: DATA_W] = c.wdata;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("req_ready_seen_%0d", i), 64'(got), 64'd1);
    if (got) begin
      e.idx   = i;
      e.rdata = exp_rd;
      e.err   = exp_err;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid[i] = 1'b0;
  endtask

  // Monitor / scoreboard.
  exp_t mon_e;
  int   mon_g;
  always @(negedge clk) begin
    if (!rst) begin
      if (|req_ready) begin
        check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        if (exp_grant.size() > 0) begin
          mon_g = exp_grant.pop_front();
          check("grant_order", 64'(idx_of(req_ready)), 64'(mon_g));
        end
      end
      if (|rsp_valid) begin
        check("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid %0b expected none at %0t", rsp_valid, $time);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_idx", 64'(idx_of(rsp_valid)), 64'(mon_e.idx));
          check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    #3;
    check("rst_psel", 64'(PSEL), 64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_paddr", 64'(PADDR), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single zero-wait write; PRDATA nonzero to prove rdata is masked.
    slv_waits = 0;
    slv_rdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    fork
      drive_req(0, mk_cmd(1'b1, 5'h04, 32'hDEADBEEF), 32'h0, 1'b0, 1'b0);
      begin
        @(negedge clk);
        check("wr_c0_psel", 64'(PSEL), 64'd0);
        @(negedge clk);
        check("wr_c1_psel", 64'(PSEL), 64'd1);
        check("wr_c1_penable", 64'(PENABLE), 64'd0);
        check("wr_c1_paddr", 64'(PADDR), 64'h04);
        check("wr_c1_pwdata", 64'(PWDATA), 64'hDEADBEEF);
        check("wr_c1_pwrite", 64'(PWRITE), 64'd1);
        @(negedge clk);
        check("wr_c2_penable", 64'(PENABLE), 64'd1);
        @(negedge clk);
        check("wr_c3_rsp_valid", 64'(rsp_valid), 64'b01);
        check("wr_c3_psel", 64'(PSEL), 64'd0);
      end
    join
    repeat (3) @(posedge clk);

    // Read with three wait states.
    slv_waits = 3;
    slv_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    fork
      drive_req(0, mk_cmd(1'b0, 5'h08, 32'hFFFF_FFFF), 32'h1234_5678, 1'b0, 1'b0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("rd_c1_psel", 64'(PSEL), 64'd1);
        check("rd_c1_paddr", 64'(PADDR), 64'h08);
        check("rd_c1_pwrite", 64'(PWRITE), 64'd0);
        check("rd_c1_pwdata", 64'(PWDATA), 64'd0);
        for (int c = 2; c <= 5; c++) begin
          @(negedge clk);
          check($sformatf("rd_c%0d_penable", c), 64'(PENABLE), 64'd1);
          check($sformatf("rd_c%0d_paddr", c), 64'(PADDR), 64'h08);
          check($sformatf("rd_c%0d_no_rsp", c), 64'(rsp_valid), 64'd0);
        end
        @(negedge clk);
        check("rd_c6_rsp_valid", 64'(rsp_valid), 64'b01);
        check("rd_c6_rdata", 64'(rsp_rdata), 64'h1234_5678);
      end
    join
    repeat (3) @(posedge clk);

    // Timeout: PREADY never rises.
    slv_waits = 1000;
    slv_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    fork
      drive_req(0, mk_cmd(1'b0, 5'h0C, 32'h0), 32'h0, 1'b1, 1'b0);
      begin
        int  acc = 0;
        bit  got = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("tmo_c1_psel", 64'(PSEL), 64'd1);
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (rsp_valid[0]) begin
            got = 1'b1;
            break;
          end
          if (PENABLE) acc++;
        end
        check("tmo_rsp_seen", 64'(got), 64'd1);
        check("tmo_access_cycles", 64'(acc), 64'd16);
        check("tmo_psel_low", 64'(PSEL), 64'd0);
        check("tmo_rsp_err", 64'(rsp_err), 64'd1);
      end
    join
    repeat (3) @(posedge clk);

    // Slave error on a write.
    slv_waits = 0;
    slv_err   = 1'b1;
    slv_rdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    drive_req(1, mk_cmd(1'b1, 5'h01, 32'h0000_0005), 32'h0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    slv_err = 1'b0;

    // Reset during ACCESS: transfer abandoned, then requester 0 wins first.
    slv_waits = 1000;
    @(posedge clk); #1;
    fork
      drive_req(0, mk_cmd(1'b1, 5'h0C, 32'h0000_0055), 32'h0, 1'b0, 1'b0);
    join_none
    repeat (3) @(negedge clk);
    check("pre_rst_penable", 64'(PENABLE), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_psel", 64'(PSEL), 64'd0);
    check("mid_rst_penable", 64'(PENABLE), 64'd0);
    check("mid_rst_pwrite", 64'(PWRITE), 64'd0);
    check("mid_rst_paddr", 64'(PADDR), 64'd0);
    check("mid_rst_pwdata", 64'(PWDATA), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    slv_waits = 0;
    slv_rdata = 32'h0BAD_F00D;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    @(posedge clk); #1;
    fork
      drive_req(0, mk_cmd(1'b1, 5'h02, 32'h0000_0002), 32'h0, 1'b0, 1'b0);
      drive_req(1, mk_cmd(1'b1, 5'h03, 32'h0000_0003), 32'h0, 1'b0, 1'b0);
    join
    repeat (4) @(posedge clk);

    // Round-robin: both requesters hold valid for two transfers each.
    slv_rdata = 32'hCAFE_F00D;
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    @(posedge clk); #1;
    fork
      begin
        drive_req(0, mk_cmd(1'b1, 5'h10, 32'h1111_0000), 32'h0, 1'b0, 1'b1);
        drive_req(0, mk_cmd(1'b0, 5'h12, 32'h0), 32'hCAFE_F00D, 1'b0, 1'b0);
      end
      begin
        drive_req(1, mk_cmd(1'b1, 5'h11, 32'h2222_0000), 32'h0, 1'b0, 1'b1);
        drive_req(1, mk_cmd(1'b0, 5'h1F, 32'h0), 32'hCAFE_F00D, 1'b0, 1'b0);
      end
      begin
        @(negedge clk);
        check("rr_c0_psel", 64'(PSEL), 64'd0);
        for (int c = 1; c <= 8; c++) begin
          @(negedge clk);
          check($sformatf("rr_c%0d_psel", c), 64'(PSEL), 64'd1);
          check($sformatf("rr_c%0d_penable", c), 64'(PENABLE), 64'((c % 2) == 0));
        end
        @(negedge clk);
        check("rr_c9_psel", 64'(PSEL), 64'd0);
      end
    join
    repeat (5) @(posedge clk);

    check("sb_drained", 64'(sb.size()), 64'd0);
    check("grants_drained", 64'(exp_grant.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
